sequenciador_entrada_ula: RTL and testbench
===========================================

Name: sequenciador_entrada_ula

Overview:
- Upstream stage of the ULA datapath. Debounces the two raw push-buttons and walks the user through a guided entry: operand A with carry-in, then operand B, then the operation.
- Presents registered, stable A/B/cin/seletor values plus a valid flag to the ULA.
- Outputs change only when a complete entry is committed, so HEX displays and flags never show half-entered operands.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronised button level must hold before it is accepted (10 ms at 50 MHz).
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived, not overridden).

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  synchronous reset, active-high
- SW  in  10  raw slide switches
- KEY  in  2  raw push-buttons, active-low (KEY[0]=confirm, KEY[1]=cancel)
- a_out  out  4  committed operand A
- b_out  out  4  committed operand B
- cin_out  out  1  committed carry-in
- seletor_out  out  3  committed operation select (000..110)
- valido  out  1  high while a committed entry is held
- valido_pulso  out  1  one-cycle pulse on each commit
- erro_op  out  1  one-cycle pulse when a confirm is rejected
- estado_out  out  2  current FSM state, for LEDs

Behaviour:
- Reset (clk edge with rst=1): all outputs 0, shadow registers 0, FSM=CARREGA_A, debounced key state=released (1), counters 0.
- Input sync: KEY and SW each pass through a 2-flop synchroniser before any use.
- Debounce, per key:
  - Counter clears whenever the synced level equals the stable level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the stable level takes the synced level and the counter clears.
  - Press event = stable level 1->0. It is a one-cycle pulse, occurs exactly once per press, and is never emitted on release.
- Latency: press event occurs DEBOUNCE_CYCLES+2 cycles after a clean KEY edge. The FSM acts on the same cycle as the event.
- FSM states, encoded 00/01/10/11: CARREGA_A, CARREGA_B, CARREGA_OP, PRONTO.
  - CARREGA_A + confirm: shadow A <= SW[3:0], shadow cin <= SW[8]; go to CARREGA_B.
  - CARREGA_B + confirm: shadow B <= SW[7:4]; go to CARREGA_OP.
  - CARREGA_OP + confirm, SW[2:0] != 111: shadow seletor <= SW[2:0]. Next cycle: state=PRONTO, outputs <= shadows, valido=1, valido_pulso=1 for one cycle.
  - CARREGA_OP + confirm, SW[2:0] == 111: no state change, erro_op pulses for one cycle.
  - PRONTO + confirm: go to CARREGA_A. Outputs and valido stay held until the next commit.
  - Any state + cancel: go to CARREGA_A and clear shadows. Committed outputs are unchanged.
- Simultaneous confirm and cancel in the same cycle: cancel wins and confirm is discarded.
- Holding a button produces a single event. A new event needs release then press.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.
- rst asserted mid-entry or in PRONTO: full reset as above on that clock edge. rst has priority over all events.
- SW changes outside a confirm event have no effect on any register.

Decomposition:
- Shared package holds:
  - state encodings CARREGA_A / CARREGA_B / CARREGA_OP / PRONTO;
  - op codes: SOMA=000, SUB=001, AND=010, OR=011, MULT=100, XOR=101, DIV=110, INVALIDO=111;
  - KEY_CONFIRMA=0, KEY_CANCELA=1.
- One sub-module, debounce_botao: synchroniser, counter and falling-edge pulse for one active-low button. It is instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4):
- rst for 2 cycles -> all outputs 0, estado_out=00, no pulses.
- Enter A: SW=0x105 (A=5, cin=1), press KEY0 clean -> single event, estado_out=01. Enter B: SW=0x030 (B=3), press -> estado_out=10. Enter op: SW=0x004, press -> one cycle later a_out=5, b_out=3, cin_out=1, seletor_out=100, valido=1, valido_pulso high exactly 1 cycle, estado_out=11.
- KEY0 bouncing 0/1 every cycle for 3 cycles, then steady 0 -> exactly one event. A 2-cycle low glitch -> no event.
- In CARREGA_OP with SW[2:0]=111, press KEY0 -> erro_op 1-cycle pulse, estado_out stays 10, outputs unchanged.
- From PRONTO (previous entry committed), enter A=9, then press KEY1 -> estado_out=00, a_out still 5, valido still 1.
- In CARREGA_B, KEY0 and KEY1 debounced on the same cycle -> estado_out=00. Then assert rst mid-entry -> all outputs 0 and valido=0 on the next edge.

Source files
------------

// File: rtl/sequenciador_entrada_ula_pkg.sv
// Shared definitions for the ULA input sequencer:
// FSM state encodings, operation codes and key indices.
package sequenciador_entrada_ula_pkg;

    typedef enum logic [1:0] {
        CARREGA_A  = 2'b00,
        CARREGA_B  = 2'b01,
        CARREGA_OP = 2'b10,
        PRONTO     = 2'b11
    } estado_t;

    localparam logic [2:0] OP_SOMA     = 3'b000;
    localparam logic [2:0] OP_SUB      = 3'b001;
    localparam logic [2:0] OP_AND      = 3'b010;
    localparam logic [2:0] OP_OR       = 3'b011;
    localparam logic [2:0] OP_MULT     = 3'b100;
    localparam logic [2:0] OP_XOR      = 3'b101;
    localparam logic [2:0] OP_DIV      = 3'b110;
    localparam logic [2:0] OP_INVALIDO = 3'b111;

    localparam int KEY_CONFIRMA = 0;
    localparam int KEY_CANCELA  = 1;

    function automatic logic op_valida(input logic [2:0] op);
        return op != OP_INVALIDO;
    endfunction

endpackage

// File: rtl/sequenciador_entrada_ula_if.sv
// Board-facing bundle of the ULA input sequencer:
// raw switches/keys in, committed operands and status out.
interface sequenciador_entrada_ula_if;

    logic [9:0] SW;
    logic [1:0] KEY;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic       cin_out;
    logic [2:0] seletor_out;
    logic       valido;
    logic       valido_pulso;
    logic       erro_op;
    logic [1:0] estado_out;

    modport master (
        output SW, KEY,
        input  a_out, b_out, cin_out, seletor_out,
        input  valido, valido_pulso, erro_op, estado_out
    );

    modport slave (
        input  SW, KEY,
        output a_out, b_out, cin_out, seletor_out,
        output valido, valido_pulso, erro_op, estado_out
    );

endinterface

// File: rtl/sequenciador_entrada_ula_debounce_botao.sv
// Debouncer for one active-low push-button: 2-flop sync,
// hold counter and a single-cycle press pulse.
module debounce_botao #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_pressao
);

    localparam int CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_estavel;
    logic [CNT_W-1:0] r_cnt;
    logic             w_aceita;

    assign w_aceita  = (r_sync2 != r_estavel) && (r_cnt == CNT_MAX);
    // Pulse on the very edge the stable level drops to 0.
    assign o_pressao = w_aceita && r_estavel;

    // Synchronise the key and accept a level only after it holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_estavel <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_estavel) begin
                r_cnt <= '0;
            end else if (w_aceita) begin
                r_estavel <= r_sync2;
                r_cnt     <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sequenciador_entrada_ula.sv
// Guided entry of A/cin, B and operation for the ULA;
// committed values only change on a complete valid entry.
module sequenciador_entrada_ula
    import sequenciador_entrada_ula_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                       clk,
    input  logic                       rst,
    sequenciador_entrada_ula_if.slave  bus
);

    logic [8:0] r_sw_s1;
    logic [8:0] r_sw_s2;
    logic       w_confirma;
    logic       w_cancela;

    estado_t    r_estado;
    logic [3:0] r_sh_a;
    logic [3:0] r_sh_b;
    logic       r_sh_cin;
    logic [2:0] r_sh_sel;
    logic       r_commit;

    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_cin;
    logic [2:0] r_sel;
    logic       r_valido;
    logic       r_valido_pulso;
    logic       r_erro_op;

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirma (
        .clk       (clk),
        .rst       (rst),
        .i_key_n   (bus.KEY[KEY_CONFIRMA]),
        .o_pressao (w_confirma)
    );

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancela (
        .clk       (clk),
        .rst       (rst),
        .i_key_n   (bus.KEY[KEY_CANCELA]),
        .o_pressao (w_cancela)
    );

    // Two-flop synchroniser for the slide switches in use.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= bus.SW[8:0];
            r_sw_s2 <= r_sw_s1;
        end
    end

    // Entry FSM with shadow registers and committed outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado       <= CARREGA_A;
            r_sh_a         <= '0;
            r_sh_b         <= '0;
            r_sh_cin       <= 1'b0;
            r_sh_sel       <= '0;
            r_commit       <= 1'b0;
            r_a            <= '0;
            r_b            <= '0;
            r_cin          <= 1'b0;
            r_sel          <= '0;
            r_valido       <= 1'b0;
            r_valido_pulso <= 1'b0;
            r_erro_op      <= 1'b0;
        end else begin
            r_valido_pulso <= 1'b0;
            r_erro_op      <= 1'b0;
            r_commit       <= 1'b0;
            if (r_commit) begin
                r_a            <= r_sh_a;
                r_b            <= r_sh_b;
                r_cin          <= r_sh_cin;
                r_sel          <= r_sh_sel;
                r_valido       <= 1'b1;
                r_valido_pulso <= 1'b1;
                r_estado       <= PRONTO;
            end
            if (w_cancela) begin
                r_estado <= CARREGA_A;
                r_sh_a   <= '0;
                r_sh_b   <= '0;
                r_sh_cin <= 1'b0;
                r_sh_sel <= '0;
            end else if (w_confirma) begin
                unique case (r_estado)
                    CARREGA_A: begin
                        r_sh_a   <= r_sw_s2[3:0];
                        r_sh_cin <= r_sw_s2[8];
                        r_estado <= CARREGA_B;
                    end
                    CARREGA_B: begin
                        r_sh_b   <= r_sw_s2[7:4];
                        r_estado <= CARREGA_OP;
                    end
                    CARREGA_OP: begin
                        if (op_valida(r_sw_s2[2:0])) begin
                            r_sh_sel <= r_sw_s2[2:0];
                            r_commit <= 1'b1;
                        end else begin
                            r_erro_op <= 1'b1;
                        end
                    end
                    PRONTO: begin
                        r_estado <= CARREGA_A;
                    end
                endcase
            end
        end
    end

    assign bus.a_out        = r_a;
    assign bus.b_out        = r_b;
    assign bus.cin_out      = r_cin;
    assign bus.seletor_out  = r_sel;
    assign bus.valido       = r_valido;
    assign bus.valido_pulso = r_valido_pulso;
    assign bus.erro_op      = r_erro_op;
    assign bus.estado_out   = r_estado;

endmodule

// File: tb/tb_sequenciador_entrada_ula.sv
// Bench for the ULA input sequencer: directed entries plus
// random key activity checked against a phase-level model.
module tb_sequenciador_entrada_ula;

    localparam int DEB  = 4;
    localparam int HOLD = DEB + 8;

    logic clk = 1'b0;
    logic rst;

    sequenciador_entrada_ula_if bus ();

    sequenciador_entrada_ula #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Pulse monitor: counts pulses and pulses longer than 1 cycle.
    int   n_vp       = 0;
    int   n_err      = 0;
    int   n_longo    = 0;
    logic r_vp_ant   = 1'b0;
    logic r_err_ant  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            r_vp_ant  <= 1'b0;
            r_err_ant <= 1'b0;
        end else begin
            if (bus.valido_pulso) n_vp <= n_vp + 1;
            if (bus.erro_op) n_err <= n_err + 1;
            if ((bus.valido_pulso && r_vp_ant) ||
                (bus.erro_op && r_err_ant))
                n_longo <= n_longo + 1;
            r_vp_ant  <= bus.valido_pulso;
            r_err_ant <= bus.erro_op;
        end
    end

    // Reference model: entry phase 0..3, shadows, committed view.
    int         m_fase;
    logic [3:0] m_sha, m_shb, m_a, m_b;
    logic       m_shc, m_c, m_val;
    logic [2:0] m_sel;
    int         m_vp, m_err;

    task automatic model_reset();
        m_fase = 0;
        m_sha = 0; m_shb = 0; m_shc = 0;
        m_a = 0; m_b = 0; m_c = 0; m_sel = 0; m_val = 0;
    endtask

    task automatic model_evento(input logic conf, input logic canc,
                                input logic [9:0] sw);
        if (canc) begin
            m_fase = 0;
            m_sha = 0; m_shb = 0; m_shc = 0;
        end else if (conf) begin
            if (m_fase == 0) begin
                m_sha = sw[3:0]; m_shc = sw[8]; m_fase = 1;
            end else if (m_fase == 1) begin
                m_shb = sw[7:4]; m_fase = 2;
            end else if (m_fase == 2) begin
                if (sw[2:0] == 3'd7) begin
                    m_err++;
                end else begin
                    m_a = m_sha; m_b = m_shb; m_c = m_shc;
                    m_sel = sw[2:0]; m_val = 1; m_vp++;
                    m_fase = 3;
                end
            end else begin
                m_fase = 0;
            end
        end
    endtask

    task automatic checa(input string tag, input logic [31:0] obs,
                         input logic [31:0] esp);
        checks++;
        assert (obs === esp) else begin
            failures++;
            $error("FAIL %s obs=%0h esp=%0h", tag, obs, esp);
        end
    endtask

    task automatic verifica(input string tag);
        @(posedge clk);
        #1;
        checa({tag, ".estado"}, 32'(bus.estado_out), 32'(m_fase));
        checa({tag, ".a"}, 32'(bus.a_out), 32'(m_a));
        checa({tag, ".b"}, 32'(bus.b_out), 32'(m_b));
        checa({tag, ".cin"}, 32'(bus.cin_out), 32'(m_c));
        checa({tag, ".sel"}, 32'(bus.seletor_out), 32'(m_sel));
        checa({tag, ".valido"}, 32'(bus.valido), 32'(m_val));
        checa({tag, ".n_vp"}, 32'(n_vp), 32'(m_vp));
        checa({tag, ".n_err"}, 32'(n_err), 32'(m_err));
        checa({tag, ".longo"}, 32'(n_longo), 32'd0);
    endtask

    task automatic espera(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press of the keys in mask, held, then released.
    task automatic pressiona(input logic [1:0] mask,
                             input logic [9:0] sw, input int hold);
        bus.SW = sw;
        @(negedge clk);
        bus.KEY = ~mask;
        espera(hold);
        bus.KEY = 2'b11;
        espera(HOLD);
        model_evento(mask[0], mask[1], sw);
    endtask

    initial begin
        logic [9:0] sw;
        int         r;
        m_vp = 0;
        m_err = 0;
        model_reset();
        rst = 1'b1;
        bus.SW = 10'h3ff;
        bus.KEY = 2'b11;
        espera(2);
        rst = 1'b0;
        espera(1);
        verifica("reset");
        checa("reset.vp_now", 32'(bus.valido_pulso), 32'd0);
        checa("reset.err_now", 32'(bus.erro_op), 32'd0);

        pressiona(2'b01, 10'h105, HOLD);
        verifica("entra_a");
        pressiona(2'b01, 10'h030, 40);
        verifica("entra_b_hold");
        pressiona(2'b01, 10'h004, HOLD);
        verifica("commit1");

        for (int i = 0; i < 12; i++) begin
            r = int'($urandom_range(0, 9));
            sw = 10'($urandom_range(0, 1023));
            if (r == 6 && m_fase == 2) sw[2:0] = 3'd7;
            if (r < 7) pressiona(2'b01, sw, HOLD);
            else if (r < 9) pressiona(2'b10, sw, HOLD);
            else pressiona(2'b11, sw, HOLD);
            verifica($sformatf("rand%0d", i));
        end

        // Bouncing contact settles low: one confirm event.
        sw = 10'($urandom_range(0, 1023));
        bus.SW = sw;
        @(negedge clk);
        bus.KEY = 2'b10; espera(1);
        bus.KEY = 2'b11; espera(1);
        bus.KEY = 2'b10; espera(1);
        bus.KEY = 2'b11; espera(1);
        bus.KEY = 2'b10; espera(HOLD);
        bus.KEY = 2'b11; espera(HOLD);
        model_evento(1'b1, 1'b0, sw);
        verifica("bounce");

        // Short low glitch: no event.
        bus.KEY = 2'b10; espera(2);
        bus.KEY = 2'b11; espera(HOLD);
        verifica("glitch");

        // Invalid operation is rejected in CARREGA_OP.
        pressiona(2'b10, 10'h000, HOLD);
        pressiona(2'b01, 10'h1a2, HOLD);
        pressiona(2'b01, 10'h0c0, HOLD);
        pressiona(2'b01, 10'h3ff, HOLD);
        verifica("op_invalida");

        // Commit 5/3/cin, then cancel mid-entry from PRONTO.
        pressiona(2'b10, 10'h000, HOLD);
        pressiona(2'b01, 10'h105, HOLD);
        pressiona(2'b01, 10'h030, HOLD);
        pressiona(2'b01, 10'h004, HOLD);
        verifica("commit2");
        pressiona(2'b01, 10'h000, HOLD);
        pressiona(2'b01, 10'h009, HOLD);
        verifica("a9");
        pressiona(2'b10, 10'h000, HOLD);
        verifica("cancela_pronto");

        // Both keys together in CARREGA_B: cancel wins.
        pressiona(2'b01, 10'h1f6, HOLD);
        pressiona(2'b11, 10'h0f0, HOLD);
        verifica("simultaneo");

        // Reset mid-entry clears the committed view.
        pressiona(2'b01, 10'h10e, HOLD);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        checa("rst_mid.estado", 32'(bus.estado_out), 32'd0);
        checa("rst_mid.a", 32'(bus.a_out), 32'd0);
        checa("rst_mid.b", 32'(bus.b_out), 32'd0);
        checa("rst_mid.cin", 32'(bus.cin_out), 32'd0);
        checa("rst_mid.sel", 32'(bus.seletor_out), 32'd0);
        checa("rst_mid.valido", 32'(bus.valido), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        espera(2);
        verifica("pos_rst");
        pressiona(2'b01, 10'h107, HOLD);
        verifica("pos_rst_a");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
